// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write scheduler.
//   state_t   : scheduler phase (INIT = zero sweep, RUN = arbitration)
//   SRC_A/B   : source IDs, also the bit positions of the one-hot grant
//   ZERO_REG  : address of the hard-wired zero register
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Bundle between the writeback requesters, the scheduler and the register file.
//   reqValid/Addr/Data/Ready A,B : valid/ready write requests from A and B
//   writeEnable/Address/Value    : register file write port
//   initDone                     : zero sweep finished
//   grantB                       : source of the write on the port (0 = A, 1 = B)
// Modports: master = requester/register-file side, slave = scheduler.
interface regfile_write_scheduler_if #(
  parameter int WIDTH   = 32,
  parameter int REGSIZE = 5
);

  logic               reqValidA;
  logic [REGSIZE-1:0] reqAddrA;
  logic [WIDTH-1:0]   reqDataA;
  logic               reqReadyA;

  logic               reqValidB;
  logic [REGSIZE-1:0] reqAddrB;
  logic [WIDTH-1:0]   reqDataB;
  logic               reqReadyB;

  logic               writeEnable;
  logic [REGSIZE-1:0] writeAddress;
  logic [WIDTH-1:0]   writeValue;
  logic               initDone;
  logic               grantB;

  modport master (
    output reqValidA, reqAddrA, reqDataA,
    output reqValidB, reqAddrB, reqDataB,
    input  reqReadyA, reqReadyB,
    input  writeEnable, writeAddress, writeValue, initDone, grantB
  );

  modport slave (
    input  reqValidA, reqAddrA, reqDataA,
    input  reqValidB, reqAddrB, reqDataB,
    output reqReadyA, reqReadyB,
    output writeEnable, writeAddress, writeValue, initDone, grantB
  );

endinterface

// File: rtl/regfile_write_scheduler_arbiter.sv
// wb_arbiter2: two-input combinational arbiter for the writeback port.
//   valid_a, valid_b : pending requests
//   last_grant       : source granted most recently (SRC_A / SRC_B)
//   grant            : one-hot grant, bit SRC_A for A, bit SRC_B for B
// Macro WB_RR_EN selects round-robin; undefined gives fixed priority to A.
module wb_arbiter2
  import regfile_pkg::*;
(
  input  logic       valid_a,
  input  logic       valid_b,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifdef WB_RR_EN
  always_comb begin
    // NOTE: default every output first so no path leaves grant unassigned (no latch).
    grant = '0;
    // On contention the side that did not win last time goes first.
    if (valid_a && (!valid_b || last_grant == SRC_B)) begin
      grant[SRC_A] = 1'b1;
    end else if (valid_b) begin
      grant[SRC_B] = 1'b1;
    end
  end
`else
  // Fixed priority: B only when A is idle; the pointer is irrelevant here.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant        = '0;
    grant[SRC_A] = valid_a;
    grant[SRC_B] = valid_b & ~valid_a;
  end
`endif

endmodule

// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: owns the register file's single write port.
// After reset it sweeps every register to zero (INIT), then arbitrates the
// port between writeback requesters A and B (RUN).
//   clk, rstN : clock, asynchronous active-low reset
//   bus       : slave side of regfile_write_scheduler_if (requests + write port)
// Macro WB_RR_EN (in wb_arbiter2) selects round-robin instead of A-priority.
module regfile_write_scheduler
  import regfile_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int REGSIZE = 5
) (
  input logic                       clk,
  input logic                       rstN,
  regfile_write_scheduler_if.slave  bus
);

  localparam logic [REGSIZE-1:0] LAST_ADDR = '1;

  state_t             state;
  logic [REGSIZE-1:0] sweep_cnt;
  logic               last_b;

  logic [1:0]         grant;
  logic               run;
  logic               xfer;
  logic               src;
  logic [REGSIZE-1:0] sel_addr;
  logic [WIDTH-1:0]   sel_data;

  wb_arbiter2 u_arb (
    .valid_a    (bus.reqValidA),
    .valid_b    (bus.reqValidB),
    .last_grant (last_b),
    .grant      (grant)
  );

  // Readys are combinational so a request can move in the cycle it appears.
  assign run           = (state == RUN);
  assign bus.reqReadyA = run & grant[SRC_A];
  assign bus.reqReadyB = run & grant[SRC_B];

  // The arbiter only grants valid requesters, so any grant in RUN is a transfer.
  assign xfer     = run & (|grant);
  assign src      = grant[SRC_B] ? SRC_B : SRC_A;
  assign sel_addr = grant[SRC_B] ? bus.reqAddrB : bus.reqAddrA;
  assign sel_data = grant[SRC_B] ? bus.reqDataB : bus.reqDataA;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state            <= INIT;
      sweep_cnt        <= '0;
      last_b           <= SRC_B;
      bus.writeEnable  <= 1'b0;
      bus.writeAddress <= '0;
      bus.writeValue   <= '0;
      bus.grantB       <= 1'b0;
      bus.initDone     <= 1'b0;
    end else begin
      // initDone lags the INIT->RUN change by one edge, so it rises together
      // with the first edge on which a request can be accepted.
      bus.initDone <= run;
      case (state)
        INIT: begin
          bus.writeEnable  <= 1'b1;
          bus.writeAddress <= sweep_cnt;
          bus.writeValue   <= '0;
          sweep_cnt        <= sweep_cnt + REGSIZE'(1);
          if (sweep_cnt == LAST_ADDR) begin
            state <= RUN;
          end
        end
        RUN: begin
          // A write to the zero register completes the handshake and counts
          // as a grant, but never strobes the register file.
          bus.writeEnable <= xfer && (sel_addr != REGSIZE'(ZERO_REG));
          if (xfer) begin
            bus.writeAddress <= sel_addr;
            bus.writeValue   <= sel_data;
            bus.grantB       <= src;
            last_b           <= src;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Self-checking bench for regfile_write_scheduler: a cycle model built from
// the behavioural rules is compared on every falling edge, and directed
// vectors carry hand-computed expectations. WB_RR_EN selects the expected
// arbitration policy.
module tb_regfile_write_scheduler;

  localparam int WIDTH   = 32;
  localparam int REGSIZE = 5;
  localparam int NREG    = 1 << REGSIZE;

  logic clk;
  logic rstN;

  regfile_write_scheduler_if #(.WIDTH(WIDTH), .REGSIZE(REGSIZE)) bus ();

  regfile_write_scheduler #(.WIDTH(WIDTH), .REGSIZE(REGSIZE)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register file attached to the write port.
  logic [WIDTH-1:0] regs [NREG];
  always @(posedge clk) begin
    if (bus.writeEnable === 1'b1) regs[bus.writeAddress] <= bus.writeValue;
  end

  // ---------------- behavioural model ----------------
  // m_edges counts rising edges since reset; the first NREG of them are the
  // sweep, after that the port is arbitrated.
  int               m_edges  = 0;
  bit               m_last_b = 1'b1;
  bit               m_we     = 1'b0;
  logic [REGSIZE-1:0] m_addr = '0;
  logic [WIDTH-1:0] m_val    = '0;
  bit               m_gb     = 1'b0;
  bit               m_done   = 1'b0;

  function automatic bit model_ready_a();
    bit run;
    run = rstN && (m_edges >= NREG);
`ifdef WB_RR_EN
    return run && bus.reqValidA && (!bus.reqValidB || m_last_b);
`else
    return run && bus.reqValidA;
`endif
  endfunction

  function automatic bit model_ready_b();
    bit run;
    run = rstN && (m_edges >= NREG);
`ifdef WB_RR_EN
    return run && bus.reqValidB && (!bus.reqValidA || !m_last_b);
`else
    return run && bus.reqValidB && !bus.reqValidA;
`endif
  endfunction

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      m_edges  <= 0;
      m_last_b <= 1'b1;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_val    <= '0;
      m_gb     <= 1'b0;
      m_done   <= 1'b0;
    end else begin
      if (m_edges < NREG) begin
        m_we   <= 1'b1;
        m_addr <= REGSIZE'(m_edges);
        m_val  <= '0;
      end else if (model_ready_a()) begin
        m_we     <= (bus.reqAddrA != 0);
        m_addr   <= bus.reqAddrA;
        m_val    <= bus.reqDataA;
        m_gb     <= 1'b0;
        m_last_b <= 1'b0;
      end else if (model_ready_b()) begin
        m_we     <= (bus.reqAddrB != 0);
        m_addr   <= bus.reqAddrB;
        m_val    <= bus.reqDataB;
        m_gb     <= 1'b1;
        m_last_b <= 1'b1;
      end else begin
        m_we <= 1'b0;
      end
      m_done  <= (m_edges >= NREG);
      m_edges <= m_edges + 1;
    end
  end

  always @(negedge clk) begin
    check("model_we",    bus.writeEnable,  m_we);
    check("model_addr",  bus.writeAddress, m_addr);
    check("model_val",   bus.writeValue,   m_val);
    check("model_gb",    bus.grantB,       m_gb);
    check("model_done",  bus.initDone,     m_done);
    check("model_rdy_a", bus.reqReadyA,    model_ready_a());
    check("model_rdy_b", bus.reqReadyB,    model_ready_b());
  end

  // ---------------- directed stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we"},   bus.writeEnable,  1'b0);
    check({tag, "_addr"}, bus.writeAddress, 0);
    check({tag, "_val"},  bus.writeValue,   0);
    check({tag, "_gb"},   bus.grantB,       1'b0);
    check({tag, "_done"}, bus.initDone,     1'b0);
    check({tag, "_rdya"}, bus.reqReadyA,    1'b0);
    check({tag, "_rdyb"}, bus.reqReadyB,    1'b0);
  endtask

  initial begin
    bit               exp_b;
    bit               acc_a;
    bit               acc_b;
    int               nw;
    bit               seq [2];

    rstN          = 1'b0;
    bus.reqValidA = 1'b0;
    bus.reqAddrA  = '0;
    bus.reqDataA  = '0;
    bus.reqValidB = 1'b0;
    bus.reqAddrB  = '0;
    bus.reqDataB  = '0;

    repeat (2) cycle();
    check_reset_values("por");
    rstN = 1'b1;

    // Partial sweep with valids low, interrupted at address 10.
    for (int i = 0; i <= 10; i++) begin
      cycle();
      check("sweep1_we",   bus.writeEnable,  1'b1);
      check("sweep1_addr", bus.writeAddress, i);
      check("sweep1_val",  bus.writeValue,   0);
    end
    rstN = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    #1;
    rstN = 1'b1;

    // Full sweep with B already waiting: it must not be accepted during INIT.
    bus.reqValidB = 1'b1;
    bus.reqAddrB  = 5'd1;
    bus.reqDataB  = 32'h0000_0099;
    for (int i = 0; i < NREG; i++) begin
      cycle();
      check("sweep2_we",   bus.writeEnable,  1'b1);
      check("sweep2_addr", bus.writeAddress, i);
      check("sweep2_val",  bus.writeValue,   0);
      check("sweep2_done", bus.initDone,     1'b0);
      check("sweep2_rdyb", bus.reqReadyB,    (i == NREG - 1));
    end
    cycle();
    check("first_run_we",   bus.writeEnable,  1'b1);
    check("first_run_addr", bus.writeAddress, 1);
    check("first_run_val",  bus.writeValue,   32'h0000_0099);
    check("first_run_gb",   bus.grantB,       1'b1);
    check("first_run_done", bus.initDone,     1'b1);
    bus.reqValidB = 1'b0;
    cycle();
    check("idle_we",   bus.writeEnable, 1'b0);
    check("idle_done", bus.initDone,    1'b1);
    check("idle_addr_hold", bus.writeAddress, 1);

    // Both requesters held valid for four cycles.
    bus.reqValidA = 1'b1;
    bus.reqAddrA  = 5'd3;
    bus.reqDataA  = 32'hDEAD_BEEF;
    bus.reqValidB = 1'b1;
    bus.reqAddrB  = 5'd4;
    bus.reqDataB  = 32'h1234_5678;
    for (int k = 0; k < 4; k++) begin
`ifdef WB_RR_EN
      exp_b = (k % 2 == 1);
`else
      exp_b = 1'b0;
`endif
      #1;
      check("contend_rdya", bus.reqReadyA, !exp_b);
      check("contend_rdyb", bus.reqReadyB, exp_b);
      cycle();
      check("contend_we",   bus.writeEnable,  1'b1);
      check("contend_gb",   bus.grantB,       exp_b);
      check("contend_addr", bus.writeAddress, exp_b ? 4 : 3);
      check("contend_val",  bus.writeValue,   exp_b ? 32'h1234_5678 : 32'hDEAD_BEEF);
    end
    bus.reqValidA = 1'b0;
    bus.reqValidB = 1'b0;
    cycle();
    check("contend_end_we", bus.writeEnable, 1'b0);

    // Same destination from both sides: A then B, B's data survives.
    bus.reqValidA = 1'b1;
    bus.reqAddrA  = 5'd7;
    bus.reqDataA  = 32'd1;
    bus.reqValidB = 1'b1;
    bus.reqAddrB  = 5'd7;
    bus.reqDataB  = 32'd2;
    nw = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      acc_a = bus.reqReadyA && bus.reqValidA;
      acc_b = bus.reqReadyB && bus.reqValidB;
      cycle();
      if (acc_a) bus.reqValidA = 1'b0;
      if (acc_b) bus.reqValidB = 1'b0;
      if (bus.writeEnable === 1'b1) begin
        if (nw < 2) seq[nw] = bus.grantB;
        nw++;
      end
    end
    check("same_addr_nwrites", nw, 2);
    check("same_addr_first",   seq[0], 1'b0);
    check("same_addr_second",  seq[1], 1'b1);
    check("same_addr_reg7",    regs[7], 32'd2);
    check("same_addr_valid_a", bus.reqValidA, 1'b0);
    check("same_addr_valid_b", bus.reqValidB, 1'b0);

    // Write to the zero register: accepted, never strobed.
    bus.reqValidA = 1'b1;
    bus.reqAddrA  = 5'd0;
    bus.reqDataA  = 32'hFFFF_FFFF;
    #1;
    check("zero_rdya", bus.reqReadyA, 1'b1);
    cycle();
    bus.reqValidA = 1'b0;
    check("zero_we", bus.writeEnable, 1'b0);
    cycle();
    check("zero_reg0", regs[0], 32'd0);

    // Three back-to-back A writes, then B alone, with no bubbles.
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        bus.reqValidA = 1'b1;
        bus.reqAddrA  = REGSIZE'(8 + i);
        bus.reqDataA  = 32'hA0 + i;
        bus.reqValidB = 1'b0;
      end else begin
        bus.reqValidA = 1'b0;
        bus.reqValidB = 1'b1;
        bus.reqAddrB  = 5'd11;
        bus.reqDataB  = 32'hB0;
      end
      #1;
      check("b2b_rdy", (i < 3) ? bus.reqReadyA : bus.reqReadyB, 1'b1);
      cycle();
      check("b2b_we",   bus.writeEnable,  1'b1);
      check("b2b_addr", bus.writeAddress, 8 + i);
      check("b2b_gb",   bus.grantB,       (i == 3));
    end
    bus.reqValidB = 1'b0;
    cycle();
    check("b2b_end_we", bus.writeEnable, 1'b0);
    check("b2b_reg8",  regs[8],  32'hA0);
    check("b2b_reg10", regs[10], 32'hA2);
    check("b2b_reg11", regs[11], 32'hB0);
    check("b2b_reg3",  regs[3],  32'hDEAD_BEEF);

    repeat (2) cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Sequencer and arbiter for the register file's single write port. After reset it sweeps every register to zero, since the register array has no reset of its own. It then shares the write port between two writeback requesters, A (ALU/load path) and B (multi-cycle mul/div unit), using a valid/ready handshake. It sits between the writeback stage and the register file, driving its writeEnable/writeAddress/writeValue inputs.

## Interface
- WIDTH, 32, data width of a register
- REGSIZE, 5, address width; register count is 2^REGSIZE
- clk  input  1  single clock, all state on rising edge
- rstN  input  1  asynchronous, active-low reset
- reqValidA  input  1  requester A has a write pending
- reqAddrA  input  REGSIZE  destination register for A
- reqDataA  input  WIDTH  write data for A
- reqReadyA  output  1  A's request is accepted this cycle
- reqValidB, reqAddrB, reqDataB, reqReadyB  same as A, for requester B
- writeEnable  output  1  register file write strobe
- writeAddress  output  REGSIZE  register file write address
- writeValue  output  WIDTH  register file write data
- initDone  output  1  high once the zero sweep has completed
- grantB  output  1  source of the write currently on the port: 0 = A, 1 = B

## Operation
- States: INIT and RUN. Reset forces INIT with the sweep counter at 0.
- INIT:
  - Each cycle, issue writeEnable=1, writeAddress=counter, writeValue=0, then increment the counter.
  - After issuing address 2^REGSIZE-1, move to RUN and set initDone=1.
  - reqReadyA and reqReadyB stay 0 throughout INIT.
- RUN arbitration:
  - A request transfers when reqValidX && reqReadyX.
  - At most one transfer per cycle; the ready of the granted requester is driven combinationally from the valids and the arbitration state.
  - The non-granted requester must hold valid, address and data stable until it is accepted.
- Write issue:
  - On a transfer, the next cycle drives writeEnable=1 with the granted address and data; grantB reports the source.
  - With no transfer, writeEnable=0. writeAddress, writeValue and grantB hold their last values.
- Register 0 is hard-wired zero:
  - A request to address 0 is accepted (ready asserted, handshake completes).
  - writeEnable stays 0 for that cycle.
  - It still counts as a grant for round-robin purposes.
- Simultaneous requests to the same address are serialised in grant order; the later grant's data is what remains in the register.
- An asynchronous reset mid-sweep or mid-stream drops any in-flight write and restarts INIT from address 0.

## Timing
- Reset values: writeEnable=0, writeAddress=0, writeValue=0, grantB=0, initDone=0, reqReadyA=0, reqReadyB=0. Internal pointer: last-grant = B, so A wins first under round-robin.
- INIT length:
  - The first rising edge after rstN deasserts issues address 0.
  - Addresses 0..2^REGSIZE-1 occupy 2^REGSIZE consecutive cycles.
  - initDone and the readys become possible on edge 2^REGSIZE+1.
- Latency: handshake in cycle N gives writeEnable high in cycle N+1; the register file commits at the end of N+1.
- Throughput: one write per cycle, with back-to-back grants allowed.
- Outputs writeEnable, writeAddress, writeValue, grantB and initDone are registered. The readys are combinational from the valids and the state.

## Configuration
- WB_RR_EN defined:
  - Round-robin arbitration. When both requesters are valid, the one not granted most recently wins.
  - A lone valid requester is always granted.
- WB_RR_EN undefined:
  - Fixed priority, with A always winning.
  - B is granted only in cycles where reqValidA=0. Starvation of B is accepted in this mode.

## Structure
- Shared package regfile_pkg holds:
  - the state type (INIT, RUN)
  - the source ID constants (SRC_A=0, SRC_B=1)
  - the zero-register address constant
- Sub-module wb_arbiter2 holds the two-input arbiter.
  - Inputs: valids and the last-grant pointer.
  - Outputs: one-hot grant.
  - Contains the WB_RR_EN conditional.
- The top level holds the FSM, the sweep counter and the output registers.

## Test plan
- Release reset and hold valids low: writeEnable=1 for 32 cycles with addresses 0..31 and data 0; then initDone=1 and writeEnable=0.
- Pulse rstN low at sweep address 10: all outputs return to reset values immediately; the sweep restarts at address 0 and still takes 32 cycles.
- In RUN, hold A valid (addr 3, data 0xDEADBEEF) and B valid (addr 4, data 0x12345678) for 4 cycles:
  - WB_RR_EN defined: grants alternate A, B, A, B.
  - WB_RR_EN undefined: grants are A, A, A, A and reqReadyB stays 0.
- A requests addr 0 with data 0xFFFFFFFF: reqReadyA=1, and the next cycle has writeEnable=0.
- With WB_RR_EN defined, A and B both target addr 7 (A=1, B=2) in the same cycle: writes issue on consecutive cycles as A then B, and a read of register 7 returns 2.
- A valid with B idle for 3 cycles, then B alone: 3 back-to-back writes with grantB=0, then one with grantB=1, and no bubble cycles.
